// File: rtl/memory_writer.sv
// memory_writer: downstream stage of the 32-bit word packer in the memory driver.
// Packed words are accepted over a valid/ready handshake, buffered in a small
// circular FIFO, and written to consecutive memory addresses over a req/ack
// handshake.
//
// state | meaning
// IDLE  | waiting for a buffered word; pops the FIFO head when one is present
// REQ   | mem_req asserted, address/data held until mem_ack
// STOP  | last address written (no-wrap build); back-pressure forever until reset
//
// Build option: MEMORY_WRITER_WRAP_EN
//   defined   -> the address wraps to 0 after the top address (ring buffer),
//                STOP is never entered and mem_full is tied 0.
//   undefined -> the ack for the top address sends the FSM to STOP, mem_full=1.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   in_data        packed word from the packer
//   in_valid       in_data valid this cycle
//   in_ready       block accepts in_data this cycle (registered)
//   mem_req        memory write request
//   mem_addr       write address, stable while mem_req=1
//   mem_wdata      write data, stable while mem_req=1
//   mem_ack        memory accepted the write (1-cycle pulse)
//   mem_full       top address written, sticky (no-wrap build)
//   words_written  count of completed writes, wraps mod 2**(ADDR_W+1)
module memory_writer #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  output logic              mem_full,
  output logic [ADDR_W:0]   words_written
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_next;
  logic [ADDR_W-1:0] addr_cnt;
  logic              push, pop, ack_take;

  assign push = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    mem_req    = 1'b0;
    ack_take   = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ack_take = 1'b1;
`ifdef MEMORY_WRITER_WRAP_EN
          state_next = IDLE;
`else
          state_next = (addr_cnt == '1) ? STOP : IDLE;
`endif
        end
      end
      STOP:    state_next = STOP;
      default: state_next = IDLE;
    endcase
  end

  assign count_next = count + CNT_W'(push) - CNT_W'(pop);

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= in_data;
  end

  // Pointers wrap for free because FIFO_DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_next;
      // Registered from next-cycle occupancy so in_ready never lets a push
      // land in a full FIFO.
      in_ready <= (count_next != CNT_W'(FIFO_DEPTH)) && (state_next != STOP);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr      <= '0;
      mem_wdata     <= '0;
      addr_cnt      <= '0;
      words_written <= '0;
    end else begin
      if (pop) begin
        mem_wdata <= fifo_mem[rd_ptr];
        mem_addr  <= addr_cnt;
      end
      if (ack_take) begin
        addr_cnt      <= addr_cnt + 1'b1;
        words_written <= words_written + 1'b1;
      end
    end
  end

`ifdef MEMORY_WRITER_WRAP_EN
  assign mem_full = 1'b0;
`else
  assign mem_full = (state == STOP);
`endif

endmodule

// File: tb/tb_memory_writer.sv
module tb_memory_writer;

  localparam int MEM_WORDS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_req;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic        mem_full;
  logic [4:0]  words_written;

  memory_writer dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_full(mem_full), .words_written(words_written)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: every accepted word must be written, in order, to
  // address (write index mod 16); completed writes are simply counted.
  logic [31:0] q[$];
  int          writes = 0;
  int          pushes = 0;
  logic        stall = 1'b0;
  logic [3:0]  hold_addr;
  logic [31:0] hold_data;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    writes = 0;
    pushes = 0;
    stall  = 1'b0;
  endtask

  task automatic monitor();
    logic [31:0] exp_w;
    if (!rst) begin
      stall = 1'b0;
      return;
    end
    check("words_written", {59'd0, words_written}, 64'(writes % 32));
`ifdef MEMORY_WRITER_WRAP_EN
    check("mem_full", {63'd0, mem_full}, 64'd0);
`else
    check("mem_full", {63'd0, mem_full}, 64'(writes >= MEM_WORDS));
    if (writes >= MEM_WORDS) begin
      check("in_ready_stop", {63'd0, in_ready}, 64'd0);
      check("mem_req_stop", {63'd0, mem_req}, 64'd0);
    end
`endif
    if (stall) begin
      check("req_hold", {63'd0, mem_req}, 64'd1);
      check("addr_hold", {60'd0, mem_addr}, {60'd0, hold_addr});
      check("wdata_hold", {32'd0, mem_wdata}, {32'd0, hold_data});
    end
    stall     = mem_req && !mem_ack;
    hold_addr = mem_addr;
    hold_data = mem_wdata;
    if (in_valid && in_ready) begin
      q.push_back(in_data);
      pushes++;
    end
    if (mem_req && mem_ack) begin
      if (q.size() == 0) check("write_without_word", 64'd1, 64'd0);
      else begin
        exp_w = q.pop_front();
        check("write_data", {32'd0, mem_wdata}, {32'd0, exp_w});
      end
      check("write_addr", {60'd0, mem_addr}, 64'(writes % MEM_WORDS));
      writes++;
    end
  endtask

  // Inputs are driven 1 time unit after the rising edge; the model samples
  // at the falling edge in between.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output int lat);
    lat = 0;
    while (!mem_req && lat < 30) begin
      tick();
      lat++;
    end
    if (!mem_req) check("wait_req_timeout", 64'd1, 64'd0);
  endtask

  typedef struct {
    logic [31:0] data;
    int          ack_delay;
    logic [3:0]  exp_addr;
    logic [4:0]  exp_ww;
  } vec_t;

  vec_t vt[5];

  initial begin
    int lat, k, cyc, start_w, start_p, target;
    logic acc;

    vt[0] = '{32'h01020304, 0, 4'd0, 5'd1};
    vt[1] = '{32'hDEADBEEF, 3, 4'd1, 5'd2};
    vt[2] = '{32'h00000000, 1, 4'd2, 5'd3};
    vt[3] = '{32'hFFFFFFFF, 5, 4'd3, 5'd4};
    vt[4] = '{32'h5A5AA5A5, 2, 4'd4, 5'd5};

    // Reset state
    #1;
    repeat (2) tick();
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_mem_req", {63'd0, mem_req}, 64'd0);
    check("rst_mem_addr", {60'd0, mem_addr}, 64'd0);
    check("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
    check("rst_mem_full", {63'd0, mem_full}, 64'd0);
    check("rst_words_written", {59'd0, words_written}, 64'd0);
    rst = 1'b1;
    model_reset();
    tick();

    // Single-word transactions: latency, address sequence, ack delays
    for (int i = 0; i < 5; i++) begin
      check("vec_in_ready", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b1;
      in_data  = vt[i].data;
      tick();
      in_valid = 1'b0;
      in_data  = $urandom;
      check("vec_req_t1", {63'd0, mem_req}, 64'd0);
      tick();
      check("vec_req_t2", {63'd0, mem_req}, 64'd1);
      check("vec_addr", {60'd0, mem_addr}, {60'd0, vt[i].exp_addr});
      check("vec_wdata", {32'd0, mem_wdata}, {32'd0, vt[i].data});
      repeat (vt[i].ack_delay) tick();
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      check("vec_req_drop", {63'd0, mem_req}, 64'd0);
      check("vec_ww", {59'd0, words_written}, {59'd0, vt[i].exp_ww});
      tick();
    end

    // Reset while requesting address 5
    in_valid = 1'b1;
    in_data  = 32'hCAFE0005;
    tick();
    in_valid = 1'b0;
    wait_req(lat);
    check("rst5_addr_before", {60'd0, mem_addr}, 64'd5);
    #2 rst = 1'b0;
    #1;
    check("rst5_mem_req", {63'd0, mem_req}, 64'd0);
    check("rst5_mem_addr", {60'd0, mem_addr}, 64'd0);
    check("rst5_words_written", {59'd0, words_written}, 64'd0);
    model_reset();
    tick();
    rst = 1'b1;
    tick();
    in_valid = 1'b1;
    in_data  = 32'h12345678;
    tick();
    in_valid = 1'b0;
    wait_req(lat);
    check("rst5_next_addr", {60'd0, mem_addr}, 64'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();

    // Ack pulse while idle and empty is ignored
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("idle_ack_req", {63'd0, mem_req}, 64'd0);
    tick();
    check("idle_ack_ww", {59'd0, words_written}, 64'd1);
    check("idle_ack_addr", {60'd0, mem_addr}, 64'd0);

    // Back-to-back words with ack held low: 5 absorbed, 6th waits
    k = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1;
      in_data  = 32'hA0 + 32'(k);
      acc = in_ready;
      tick();
      if (acc) k++;
    end
    check("b2b_absorbed", 64'(k), 64'd5);
    check("b2b_in_ready", {63'd0, in_ready}, 64'd0);
    start_w = writes;
    cyc = 0;
    while ((k < 6 || writes < start_w + 6) && cyc < 200) begin
      in_valid = (k < 6);
      in_data  = 32'hA0 + 32'(k);
      mem_ack  = mem_req;
      acc = in_valid && in_ready;
      tick();
      if (acc) k++;
      cyc++;
    end
    in_valid = 1'b0;
    mem_ack  = 1'b0;
    check("b2b_all_written", 64'(writes - start_w), 64'd6);
    tick();

    // Random traffic from reset until the memory fills (or wraps)
    rst = 1'b0;
    tick();
    model_reset();
    rst = 1'b1;
`ifdef MEMORY_WRITER_WRAP_EN
    target = MEM_WORDS + 4;
`else
    target = MEM_WORDS;
`endif
    cyc = 0;
    while (writes < target && cyc < 3000) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = $urandom;
      mem_ack  = ($urandom_range(0, 2) != 0);
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    mem_ack  = 1'b0;
    check("rand_writes_done", 64'(writes), 64'(target));
    tick();
`ifdef MEMORY_WRITER_WRAP_EN
    check("wrap_mem_full", {63'd0, mem_full}, 64'd0);
    check("wrap_ww", {59'd0, words_written}, 64'(target % 32));
`else
    check("full_mem_full", {63'd0, mem_full}, 64'd1);
    check("full_ww", {59'd0, words_written}, 64'd16);
    start_p = pushes;
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      mem_ack  = $urandom_range(0, 1) != 0;
      tick();
    end
    in_valid = 1'b0;
    mem_ack  = 1'b0;
    check("full_no_accept", 64'(pushes), 64'(start_p));
    check("full_sticky", {63'd0, mem_full}, 64'd1);
`endif
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
